// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: ALU opcodes, loader states, operand sign extension
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } ld_state_t;

  localparam int SEXT_W = 16;

  // Bit 16 of the switch bank is the sign; replicate it above the 16-bit value.
  function automatic logic [31:0] sext_operand(input logic [16:0] v);
    return {{SEXT_W{v[16]}}, v[15:0]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debounce counter and press pulse for one active-low key
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Idle is released (1) everywhere so reset itself never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - debounced menu loader for ALU operands A, B and opcode
module alu_operand_sequencer
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  output logic [31:0] portA,
  output logic [31:0] portB,
  output aluop_t      aluop,
  output logic        operands_valid,
  output ld_state_t   ld_state
);

  logic [16:0] sw_meta;
  logic [16:0] sws;
  logic        enter_evt;
  logic        clear_evt;
  ld_state_t   state_q;
  ld_state_t   state_d;
  logic        load_a;
  logic        load_b;
  logic        load_op;
  logic        unused_inputs;

  assign unused_inputs = ^{SW[17], KEY[3:2]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sw_meta <= '0;
      sws     <= '0;
    end else begin
      sw_meta <= SW[16:0];
      sws     <= sw_meta;
    end
  end

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk   (CLK),
    .rst_n (nRST),
    .key_n (KEY[0]),
    .press (enter_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clk   (CLK),
    .rst_n (nRST),
    .key_n (KEY[1]),
    .press (clear_evt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= LOAD_A;
    else       state_q <= state_d;
  end

  // Clear outranks enter; a coincident enter is simply dropped.
  always_comb begin
    state_d = state_q;
    if (clear_evt) begin
      state_d = LOAD_A;
    end else if (enter_evt) begin
      case (state_q)
        LOAD_A:  state_d = LOAD_B;
        LOAD_B:  state_d = LOAD_OP;
        LOAD_OP: state_d = SHOW;
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_comb begin
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    if (enter_evt && !clear_evt) begin
      load_a  = (state_q == LOAD_A);
      load_b  = (state_q == LOAD_B);
      load_op = (state_q == LOAD_OP);
    end
  end

  // Operands move only on load or clear edges so the ALU never sees glitches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      portA          <= '0;
      portB          <= '0;
      aluop          <= ALU_SLL;
      operands_valid <= 1'b0;
    end else begin
      operands_valid <= (state_d == SHOW);
      if (clear_evt) begin
        portA <= '0;
        portB <= '0;
        aluop <= ALU_SLL;
      end else begin
        if (load_a)  portA <= sext_operand(sws);
        if (load_b)  portB <= sext_operand(sws);
        if (load_op) aluop <= aluop_t'(sws[3:0]);
      end
    end
  end

  assign ld_state = state_q;

endmodule
